branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor and resolution checker for the MIPS pipeline. At fetch it looks up a table of 2-bit saturating counters, indexed by PC, and returns a taken/not-taken prediction. At execute it takes the resolved branch outcome from the branch-condition logic and trains the table. On a wrong prediction it raises a one-cycle registered mispredict pulse with the correct redirect PC.

## Interface
- INDEX_BITS, 6, log2 of table entries (64 entries by default)
- INIT_STATE, 2'b01, counter value written to every entry during initialisation (weakly not-taken)

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- if_valid  input  1  fetch lookup request
- if_pc  input  32  fetch PC
- pred_taken  output  1  prediction for if_pc (combinational read)
- busy  output  1  table initialisation in progress
- ex_valid  input  1  execute-stage instruction valid
- ex_is_branch  input  1  execute-stage instruction is a conditional branch
- ex_pc  input  32  PC of the resolving branch
- ex_pred_taken  input  1  prediction made at fetch for this branch, carried down the pipeline
- ex_take_branch  input  1  resolved outcome
- ex_target  input  32  branch target address
- ex_fallthrough  input  32  not-taken continuation PC (after the delay slot)
- mispredict  output  1  registered one-cycle redirect pulse
- redirect_pc  output  32  registered correct PC; valid only while mispredict=1

## Operation
- Index = pc[INDEX_BITS+1:2]. Entries are 2-bit counters; prediction = counter[1].
- FSM states: INIT and RUN.
  - rst=1: state becomes INIT, init_idx becomes 0, mispredict becomes 0, redirect_pc becomes 0.
  - INIT: each cycle writes INIT_STATE to entry init_idx, then increments init_idx. After entry 2^INDEX_BITS-1 is written, state becomes RUN.
  - RUN: state is terminal until the next rst.
- busy = (state==INIT). While busy: pred_taken=0 and training writes are suppressed.
- pred_taken = if_valid & !busy & table[idx(if_pc)][1]. When if_valid=0, pred_taken=0.
- Training, when RUN & ex_valid & ex_is_branch:
  - taken: the counter increments, saturating at 11.
  - not taken: the counter decrements, saturating at 00.
- Mispredict detection is independent of busy. The registered values are:
  - mispredict <= ex_valid & ex_is_branch & (ex_pred_taken != ex_take_branch)
  - redirect_pc <= ex_take_branch ? ex_target : ex_fallthrough
- On a correct prediction or a non-branch, mispredict <= 0 and redirect_pc holds its value.
- Same-index read and write in one cycle: the read returns the pre-update value; there is no bypass.
- Aliasing: distinct PCs with equal index share one counter. There are no tags.

## Timing
- Prediction: zero-cycle combinational from if_pc.
- Training: the counter update is visible to a lookup starting the cycle after ex_valid.
- Mispredict: asserted the cycle after resolution, high for exactly one cycle per mispredicting branch. Back-to-back mispredicting branches produce back-to-back pulses.
- After rst deasserts, busy stays high for exactly 2^INDEX_BITS cycles. busy is also high during the rst cycle itself.
- Reset mid-operation, in INIT or RUN: initialisation restarts from index 0 and any pending mispredict is dropped.
- Reset values: pred_taken=0, busy=1, mispredict=0, redirect_pc=0; stat counters are 0 when present.

## Configuration
- BRANCH_PRED_STATS_EN defined:
  - Adds output stat_branches [31:0], which counts trained branches (RUN & ex_valid & ex_is_branch).
  - Adds output stat_mispredicts [31:0], which counts mispredict pulses.
  - Both counters wrap modulo 2^32 and are cleared only by rst.
- BRANCH_PRED_STATS_EN undefined: both ports and their counters are absent, and all other behaviour is identical.

## Test plan
- Reset/init: pulse rst for 1 cycle with INDEX_BITS=6 -> busy=1 for 64 cycles after rst, pred_taken=0 throughout; busy=0 on the 65th cycle; every lookup then returns 0 (INIT_STATE=01).
- Training and redirect: branch ex_pc=0x00400010, ex_pred_taken=0, ex_take_branch=1, ex_target=0x00400100 -> next cycle mispredict=1, redirect_pc=0x00400100; counter goes 01->10 and if_pc=0x00400010 then predicts 1.
- Saturation: five taken resolutions at 0x00400010 -> counter holds 11; one not-taken -> 10, still predicts 1; a second not-taken -> 01, predicts 0.
- Wrong taken prediction: ex_pred_taken=1, ex_take_branch=0, ex_fallthrough=0x00400018 -> mispredict=1 for one cycle, redirect_pc=0x00400018; a correct prediction in the following cycle -> mispredict=0.
- Aliasing and same-cycle read/write: train 0x00400010 taken while if_pc=0x00400110 (same index 4) in the same cycle -> pred_taken shows the old value that cycle and the new value the next cycle.
- Mid-operation reset: assert rst while a mispredict is pending and the table is trained -> mispredict=0 and busy=1 the next cycle, table re-initialised to 01; with BRANCH_PRED_STATS_EN, both stat counters read 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: PC-indexed table of 2-bit saturating counters with
// execute-stage training and a registered mispredict/redirect pulse. Define BRANCH_PRED_STATS_EN for counters.
module branch_predictor #(
  parameter int unsigned INDEX_BITS = 6,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic        busy,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_pred_taken,
  input  logic        ex_take_branch,
  input  logic [31:0] ex_target,
  input  logic [31:0] ex_fallthrough,
  output logic        mispredict,
  output logic [31:0] redirect_pc
`ifdef BRANCH_PRED_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int unsigned DEPTH = 1 << INDEX_BITS;
  localparam logic [INDEX_BITS-1:0] LAST_IDX = '1;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [INDEX_BITS-1:0]   init_idx_q, init_idx_d;
  logic [1:0]              table_q [DEPTH];
  logic [1:0]              table_d [DEPTH];
  logic                    mispredict_q, mispredict_d;
  logic [31:0]             redirect_pc_q, redirect_pc_d;

  logic [INDEX_BITS-1:0]   if_idx;
  logic [INDEX_BITS-1:0]   ex_idx;
  logic                    train;
  logic                    wrong;
  logic [1:0]              ex_ctr;

  assign if_idx = if_pc[INDEX_BITS+1:2];
  assign ex_idx = ex_pc[INDEX_BITS+1:2];

  // The rst cycle counts as busy so a mid-run reset never trains or predicts.
  assign busy       = (state_q == INIT) | rst;
  assign pred_taken = if_valid & ~busy & table_q[if_idx][1];
  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_pc_q;

  assign train  = ~busy & ex_valid & ex_is_branch;
  assign wrong  = ex_valid & ex_is_branch & (ex_pred_taken != ex_take_branch);
  assign ex_ctr = table_q[ex_idx];

  always_comb begin
    state_d       = state_q;
    init_idx_d    = init_idx_q;
    table_d       = table_q;
    mispredict_d  = wrong;
    redirect_pc_d = redirect_pc_q;

    if (wrong) begin
      redirect_pc_d = ex_take_branch ? ex_target : ex_fallthrough;
    end

    case (state_q)
      INIT: begin
        table_d[init_idx_q] = INIT_STATE;
        init_idx_d          = init_idx_q + 1'b1;
        if (init_idx_q == LAST_IDX) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (train) begin
          if (ex_take_branch && ex_ctr != 2'b11) begin
            table_d[ex_idx] = ex_ctr + 2'b01;
          end else if (!ex_take_branch && ex_ctr != 2'b00) begin
            table_d[ex_idx] = ex_ctr - 2'b01;
          end
        end
      end
      default: state_d = INIT;
    endcase

    if (rst) begin
      state_d       = INIT;
      init_idx_d    = '0;
      mispredict_d  = 1'b0;
      redirect_pc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q       <= state_d;
    init_idx_q    <= init_idx_d;
    mispredict_q  <= mispredict_d;
    redirect_pc_q <= redirect_pc_d;
  end

  // Table contents are established by the INIT walk, so no reset is needed here.
  always_ff @(posedge clk) begin
    table_q <= table_d;
  end

`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (train) begin
      stat_branches_d = stat_branches_q + 32'd1;
    end
    if (mispredict_d) begin
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end
    if (rst) begin
      stat_branches_d    = '0;
      stat_mispredicts_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    stat_branches_q    <= stat_branches_d;
    stat_mispredicts_q <= stat_mispredicts_d;
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: init walk, training, saturation, redirect
// pulses, aliasing with same-cycle read/write, and mid-operation reset.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        busy;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic        ex_take_branch;
  logic [31:0] ex_target;
  logic [31:0] ex_fallthrough;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int assertions;
  int failures;

  branch_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .busy           (busy),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_pc          (ex_pc),
    .ex_pred_taken  (ex_pred_taken),
    .ex_take_branch (ex_take_branch),
    .ex_target      (ex_target),
    .ex_fallthrough (ex_fallthrough),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc)
`ifdef BRANCH_PRED_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one execute-stage branch for a single cycle, then drop ex_valid.
  task automatic resolve(input logic [31:0] pc, input logic pred, input logic take,
                         input logic [31:0] target, input logic [31:0] ft);
    ex_valid       = 1'b1;
    ex_is_branch   = 1'b1;
    ex_pc          = pc;
    ex_pred_taken  = pred;
    ex_take_branch = take;
    ex_target      = target;
    ex_fallthrough = ft;
    step();
    ex_valid       = 1'b0;
  endtask

  // Count busy cycles after rst has dropped, checking predictions are suppressed.
  task automatic wait_init(input string name);
    int n;
    n = 0;
    if_valid = 1'b1;
    while (busy && n < 200) begin
      if_pc = 32'h0040_0000 + (32'($urandom_range(0, 63)) << 2);
      assertions++;
      if (pred_taken !== 1'b0) begin
        failures++;
        $display("FAIL %s_pred_while_busy: got %b expected 0", name, pred_taken);
      end
      n++;
      step();
    end
    assertions++;
    if (n !== 64) begin
      failures++;
      $display("FAIL %s_busy_cycles: got %0d expected 64", name, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    assertions++;
    if (busy !== 1'b1 || mispredict !== 1'b0 || redirect_pc !== 32'h0 || pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b misp=%b rpc=%h pred=%b expected 1 0 0 0",
               busy, mispredict, redirect_pc, pred_taken);
    end
`ifdef BRANCH_PRED_STATS_EN
    assertions++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      failures++;
      $display("FAIL reset_stats: got %0d %0d expected 0 0", stat_branches, stat_mispredicts);
    end
`endif
    rst = 1'b0;
    wait_init("reset");
    if_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if_pc = 32'h0040_0000 + (32'(i) << 2);
      #1;
      assertions++;
      if (pred_taken !== 1'b0) begin
        failures++;
        $display("FAIL init_lookup_%0d: got %b expected 0", i, pred_taken);
      end
    end
  endtask

  task automatic test_train_redirect();
    resolve(32'h0040_0010, 1'b0, 1'b1, 32'h0040_0100, 32'h0040_0018);
    assertions++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h0040_0100) begin
      failures++;
      $display("FAIL train_redirect: got misp=%b rpc=%h expected 1 00400100", mispredict, redirect_pc);
    end
    if_valid = 1'b1;
    if_pc    = 32'h0040_0010;
    #1;
    assertions++;
    if (pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL train_pred: got %b expected 1", pred_taken);
    end
    step();
    assertions++;
    if (mispredict !== 1'b0 || redirect_pc !== 32'h0040_0100) begin
      failures++;
      $display("FAIL train_pulse_end: got misp=%b rpc=%h expected 0 00400100", mispredict, redirect_pc);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      resolve(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, 32'h0040_0018);
      assertions++;
      if (mispredict !== 1'b0) begin
        failures++;
        $display("FAIL sat_correct_%0d: got misp=%b expected 0", i, mispredict);
      end
    end
    if_pc = 32'h0040_0010;
    resolve(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100, 32'h0040_0018);
    assertions++;
    if (pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL sat_first_dec: got %b expected 1", pred_taken);
    end
    resolve(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100, 32'h0040_0018);
    assertions++;
    if (pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL sat_second_dec: got %b expected 0", pred_taken);
    end
  endtask

  task automatic test_wrong_taken();
    resolve(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100, 32'h0040_0018);
    assertions++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h0040_0018) begin
      failures++;
      $display("FAIL wrong_taken: got misp=%b rpc=%h expected 1 00400018", mispredict, redirect_pc);
    end
    resolve(32'h0040_0010, 1'b0, 1'b0, 32'h0040_0200, 32'h0040_0300);
    assertions++;
    if (mispredict !== 1'b0 || redirect_pc !== 32'h0040_0018) begin
      failures++;
      $display("FAIL wrong_then_correct: got misp=%b rpc=%h expected 0 00400018", mispredict, redirect_pc);
    end
  endtask

  task automatic test_back_to_back();
    resolve(32'h0040_0020, 1'b1, 1'b0, 32'h0040_0500, 32'h0040_0028);
    assertions++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h0040_0028) begin
      failures++;
      $display("FAIL b2b_first: got misp=%b rpc=%h expected 1 00400028", mispredict, redirect_pc);
    end
    resolve(32'h0040_0030, 1'b0, 1'b1, 32'h0040_0600, 32'h0040_0038);
    assertions++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h0040_0600) begin
      failures++;
      $display("FAIL b2b_second: got misp=%b rpc=%h expected 1 00400600", mispredict, redirect_pc);
    end
    ex_is_branch = 1'b0;
    ex_valid     = 1'b1;
    ex_pred_taken = 1'b1;
    step();
    ex_valid = 1'b0;
    assertions++;
    if (mispredict !== 1'b0 || redirect_pc !== 32'h0040_0600) begin
      failures++;
      $display("FAIL b2b_nonbranch: got misp=%b rpc=%h expected 0 00400600", mispredict, redirect_pc);
    end
  endtask

  task automatic test_alias();
    // Entry 4 is at 00 here; one taken brings it to 01.
    resolve(32'h0040_0010, 1'b0, 1'b1, 32'h0040_0100, 32'h0040_0018);
    if_valid = 1'b1;
    if_pc    = 32'h0040_0110;
    ex_valid       = 1'b1;
    ex_is_branch   = 1'b1;
    ex_pc          = 32'h0040_0010;
    ex_pred_taken  = 1'b0;
    ex_take_branch = 1'b1;
    #1;
    assertions++;
    if (pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL alias_same_cycle: got %b expected 0", pred_taken);
    end
    step();
    ex_valid = 1'b0;
    #1;
    assertions++;
    if (pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL alias_next_cycle: got %b expected 1", pred_taken);
    end
    if_valid = 1'b0;
    #1;
    assertions++;
    if (pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL alias_if_invalid: got %b expected 0", pred_taken);
    end
  endtask

  task automatic test_mid_reset();
    resolve(32'h0040_0010, 1'b0, 1'b1, 32'h0040_0100, 32'h0040_0018);
    assertions++;
    if (mispredict !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pending: got misp=%b expected 1", mispredict);
    end
    rst = 1'b1;
    #1;
    assertions++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_busy_in_rst: got %b expected 1", busy);
    end
    resolve(32'h0040_0010, 1'b0, 1'b1, 32'h0040_0100, 32'h0040_0018);
    assertions++;
    if (mispredict !== 1'b0 || busy !== 1'b1 || redirect_pc !== 32'h0) begin
      failures++;
      $display("FAIL midrst_outputs: got misp=%b busy=%b rpc=%h expected 0 1 0", mispredict, busy, redirect_pc);
    end
`ifdef BRANCH_PRED_STATS_EN
    assertions++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      failures++;
      $display("FAIL midrst_stats: got %0d %0d expected 0 0", stat_branches, stat_mispredicts);
    end
`endif
    rst = 1'b0;
    wait_init("midrst");
    if_valid = 1'b1;
    if_pc    = 32'h0040_0010;
    #1;
    assertions++;
    if (pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL midrst_reinit: got %b expected 0", pred_taken);
    end
    resolve(32'h0040_0010, 1'b0, 1'b1, 32'h0040_0100, 32'h0040_0018);
    assertions++;
    if (pred_taken !== 1'b1) begin
      failures++;
      $display("FAIL midrst_retrain: got %b expected 1", pred_taken);
    end
  endtask

  initial begin
    assertions     = 0;
    failures       = 0;
    rst            = 1'b1;
    if_valid       = 1'b0;
    if_pc          = '0;
    ex_valid       = 1'b0;
    ex_is_branch   = 1'b0;
    ex_pc          = '0;
    ex_pred_taken  = 1'b0;
    ex_take_branch = 1'b0;
    ex_target      = '0;
    ex_fallthrough = '0;
    #1;
    test_reset();
    test_train_redirect();
    test_saturation();
    test_wrong_taken();
    test_back_to_back();
    test_alias();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
